// File: rtl/hybrid_ca_pkg.sv
// Shared constants and types for the hybrid rule-90/150 CA generator.
package hybrid_ca_pkg;

    localparam int BND_NULL     = 0;
    localparam int BND_PERIODIC = 1;
    localparam int CNT_W        = 16;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } fsm_state_e;

endpackage

// File: rtl/hybrid_ca_next.sv
// Combinational next-state map of a hybrid rule-90/150 CA; zero latency, no flow control.
module hybrid_ca_next
    import hybrid_ca_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RULE_MASK = 8'h55,
    parameter int               BOUNDARY  = BND_NULL
) (
    input  logic [WIDTH-1:0] state,
    output logic [WIDTH-1:0] nxt
);

    logic             edge_l;
    logic             edge_r;
    logic [WIDTH-1:0] left_nb;
    logic [WIDTH-1:0] right_nb;

    // End cells see either 0 or the opposite end, depending on the boundary mode.
    assign edge_l   = (BOUNDARY == BND_PERIODIC) ? state[WIDTH-1] : 1'b0;
    assign edge_r   = (BOUNDARY == BND_PERIODIC) ? state[0]       : 1'b0;
    assign left_nb  = {state[WIDTH-2:0], edge_l};
    assign right_nb = {edge_r, state[WIDTH-1:1]};
    assign nxt      = left_nb ^ right_nb ^ (state & RULE_MASK);

endmodule

// File: rtl/hybrid_ca_gen.sv
// Hybrid CA pattern generator: seed load, single steps and counted bursts (busy/done).
// Optional cycle-length measurement when CA_PERIOD_DETECT_EN is defined.
module hybrid_ca_gen
    import hybrid_ca_pkg::*;
#(
    parameter int               WIDTH      = 8,
    parameter logic [WIDTH-1:0] RULE_MASK  = 8'h55,
    parameter int               BOUNDARY   = BND_NULL,
    parameter logic [WIDTH-1:0] RESET_SEED = {1'b1, {(WIDTH-1){1'b0}}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] seed,
    input  logic             step_en,
    input  logic             start,
    input  logic [CNT_W-1:0] burst_len,
    output logic [WIDTH-1:0] state,
    output logic             busy,
    output logic             done,
    output logic             zero_state,
    output logic [CNT_W-1:0] period,
    output logic             period_valid
);

    logic [WIDTH-1:0] nxt;
    logic [WIDTH-1:0] state_q, state_d;
    fsm_state_e       fsm_q, fsm_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [CNT_W-1:0] rem_q, rem_d;

    hybrid_ca_next #(
        .WIDTH    (WIDTH),
        .RULE_MASK(RULE_MASK),
        .BOUNDARY (BOUNDARY)
    ) u_next (
        .state(state_q),
        .nxt  (nxt)
    );

    always_comb begin
        state_d = state_q;
        fsm_d   = fsm_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        rem_d   = rem_q;
        if (load) begin
            // Load also aborts a running burst without a done pulse.
            state_d = seed;
            fsm_d   = ST_IDLE;
            busy_d  = 1'b0;
            rem_d   = '0;
        end else begin
            case (fsm_q)
                ST_IDLE: begin
                    if (start) begin
                        if (burst_len == '0) begin
                            done_d = 1'b1;
                        end else begin
                            rem_d  = burst_len;
                            fsm_d  = ST_RUN;
                            busy_d = 1'b1;
                        end
                    end else if (step_en) begin
                        state_d = nxt;
                    end
                end
                ST_RUN: begin
                    state_d = nxt;
                    rem_d   = rem_q - 16'd1;
                    if (rem_q == 16'd1) begin
                        fsm_d  = ST_IDLE;
                        busy_d = 1'b0;
                        done_d = 1'b1;
                    end
                end
                default: fsm_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RESET_SEED;
            fsm_q   <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            fsm_q   <= fsm_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            rem_q   <= rem_d;
        end
    end

    assign state      = state_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign zero_state = (state_q == '0);

`ifdef CA_PERIOD_DETECT_EN
    logic             step_applied;
    logic [WIDTH-1:0] ref_q, ref_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic             pvalid_q, pvalid_d;

    assign step_applied = !load && ((fsm_q == ST_RUN) || (!start && step_en));

    // After a match, or once saturated, the counter freezes until the next load/reset.
    always_comb begin
        ref_d    = ref_q;
        cnt_d    = cnt_q;
        period_d = period_q;
        pvalid_d = pvalid_q;
        if (load) begin
            ref_d    = seed;
            cnt_d    = '0;
            period_d = '0;
            pvalid_d = 1'b0;
        end else if (step_applied && !pvalid_q && (cnt_q != 16'hFFFF)) begin
            cnt_d = cnt_q + 16'd1;
            if (nxt == ref_q) begin
                period_d = cnt_q + 16'd1;
                pvalid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ref_q    <= RESET_SEED;
            cnt_q    <= '0;
            period_q <= '0;
            pvalid_q <= 1'b0;
        end else begin
            ref_q    <= ref_d;
            cnt_q    <= cnt_d;
            period_q <= period_d;
            pvalid_q <= pvalid_d;
        end
    end

    assign period       = period_q;
    assign period_valid = pvalid_q;
`else
    assign period       = '0;
    assign period_valid = 1'b0;
`endif

endmodule

// File: doc/hybrid_ca_gen.md
# hybrid_ca_gen

Parametrised hybrid rule-90/150 cellular-automaton pattern generator. Each cell's rule is selected per bit, and the boundary mode is selectable. It supports seed loading, free-running single steps, and counted bursts with a busy/done handshake. It serves as the configurable successor to the fixed 4-cell CA and feeds BIST/test-pattern and scrambler consumers.

## Interface
- WIDTH, 8: number of cells (≥3); cell i is state[i], neighbours i-1 and i+1.
- RULE_MASK, 8'h55: per-cell rule select. Bit i=1 selects rule 150 (l^s^r); bit i=0 selects rule 90 (l^r). Width is WIDTH.
- BOUNDARY, 0: 0 = null (missing neighbours read 0); 1 = periodic (cell 0 and cell WIDTH-1 are neighbours).
- RESET_SEED, {1'b1,{WIDTH-1{1'b0}}}: state value loaded by rst.
- clk  in  1  clock; all state changes on its rising edge.
- rst  in  1  reset, asynchronous, active-high.
- load  in  1  load seed into state; highest priority.
- seed  in  WIDTH  value loaded when load=1.
- step_en  in  1  single step per cycle while idle.
- start  in  1  begin a burst of burst_len steps; sampled only while idle.
- burst_len  in  16  burst step count, unsigned.
- state  out  WIDTH  current CA state, registered.
- busy  out  1  burst in progress.
- done  out  1  one-cycle pulse at burst completion.
- zero_state  out  1  state==0 (lock-up indicator), combinational from state.
- period  out  16  detected cycle length (see Configuration).
- period_valid  out  1  period holds a valid measurement.

## Operation
- Next-state rule for cell i: nxt[i] = L ^ R ^ (RULE_MASK[i] ? state[i] : 0). L/R are state[i∓1], or the boundary value at the ends.
- Reset values:
  - state=RESET_SEED
  - FSM=IDLE, busy=0, done=0
  - period=0, period_valid=0
  - remaining-count=0
- FSM states are IDLE and RUN.
- IDLE, in priority order:
  - load: state<=seed.
  - start with burst_len==0: done pulses, state unchanged, stays IDLE.
  - start with burst_len>0: remaining<=burst_len, go RUN, busy<=1.
  - step_en: state<=nxt.
  - otherwise hold.
  - When start and step_en are both high, start wins and step_en is ignored that cycle.
- RUN:
  - Every cycle: state<=nxt and remaining decrements.
  - When the step that brings remaining to 0 occurs: go IDLE, busy<=0, done<=1 for exactly one cycle.
  - start and step_en are ignored.
  - load aborts the burst: state<=seed, go IDLE, busy<=0, and no done pulse.
- Zero state is a fixed point: stepping keeps 0 and zero_state stays high. No auto-recovery; software must reload.
- rst mid-burst: immediate return to reset values, and no done pulse.

## Timing
- Single step: step_en high at edge k yields nxt visible on state after edge k.
- Burst: start sampled at edge k, so busy=1 after k. Steps are applied at edges k+1 … k+N. After edge k+N, state holds the Nth result, busy=0 and done=1 in that same cycle. done is 0 after edge k+N+1.
- Back-to-back: a new start is accepted at edge k+N+1, i.e. the cycle when done=1.
- load takes effect at the edge it is sampled, with no extra latency.

## Configuration
- CA_PERIOD_DETECT_EN defined:
  - A reference register captures state at reset/load.
  - A 16-bit counter increments on every applied step.
  - On the first step whose result equals the reference: period<=count+1, period_valid<=1. The counter then holds until the next load/reset.
  - The counter saturates at 16'hFFFF with period_valid staying 0.
  - load/rst clears period, period_valid and the counter.
- Macro undefined: no reference register or counter; period=0 and period_valid=0 constantly. Ports remain present.

## Structure
- Package hybrid_ca_pkg holds:
  - boundary constants BND_NULL=0 and BND_PERIODIC=1
  - FSM state enum ST_IDLE/ST_RUN
  - CNT_W=16
- One combinational sub-module, hybrid_ca_next: parameters WIDTH, RULE_MASK, BOUNDARY; maps state to nxt. The top level holds the FSM, counters and period logic.

## Test plan
- WIDTH=4, RULE_MASK=4'b0101, null boundary, RESET_SEED=4'h8, rst then step_en held: state sequence 8,4,E,F,C,A,1,3,6,B,2,5,D,9,7,8. With CA_PERIOD_DETECT_EN, period=15 and period_valid=1 after the 15th step.
- Same config, load 4'h8, start with burst_len=3: busy high 3 cycles, then state=4'hF with done=1 for one cycle, busy=0.
- WIDTH=4, RULE_MASK=0, periodic, load 4'h1, two steps: 4'hA then 4'h0. zero_state=1 and state remains 0 on further steps.
- start with burst_len=0: done pulses the next cycle, busy never asserts, state unchanged.
- Burst of 10 aborted by load 4'h3 at step 4: state=4'h3, busy=0, no done; a simultaneous step_en is ignored.
- rst asserted mid-burst, asynchronously between edges: state=RESET_SEED and busy/done/period_valid=0 immediately.
